regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_word.sv | 21 ++
 rtl/regfile_param.sv | 89 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file.
// FSM state encoding and a constant-safe clog2 helper.
package regfile_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_word.sv
// One storage word of the register file.
// Reset and clear both zero the word; clear wins over write.
module regfile_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      q <= '0;
    else if (we)
      q <= d;
  end

endmodule

// File: rtl/regfile_param.sv
// Two-read one-write register file with a background clear sweep.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             clr,
  output logic             busy
);

  logic [0:0]       state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wz;
  logic             wr_ok;
  logic             z1;
  logic             z2;

  assign busy  = (state == SWEEP);
  assign wz    = (ZERO_REG != 0) && (waddr == '0);
  assign wr_ok = wen && !busy && !wz;

  // Counter wraps to 0 on the last step, ready for the next sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr) begin
            state <= SWEEP;
            cnt   <= '0;
          end
        end
        SWEEP: begin
          if (cnt == AW'(DEPTH - 1))
            state <= IDLE;
          cnt <= cnt + AW'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    regfile_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk  (clk),
      .reset(reset),
      .we   (wr_ok && (waddr == AW'(i))),
      .clr  (busy && (cnt == AW'(i))),
      .d    (wdata),
      .q    (mem[i])
    );
  end

  assign z1 = (ZERO_REG != 0) && (raddr1 == '0);
  assign z2 = (ZERO_REG != 0) && (raddr2 == '0);

  always_comb begin
    rdata1 = z1 ? '0 : mem[raddr1];
    rdata2 = z2 ? '0 : mem[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (raddr1 == waddr))
      rdata1 = wdata;
    if (wr_ok && (raddr2 == waddr))
      rdata2 = wdata;
`endif
  end

endmodule
